// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle Moore control FSM for the 16-bit register datapath.
// Optional build macro PROC_CTRL_HALT_EN turns opcode 111 into a sticky halt.
module proc_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [DW-1:0]   din,
  output logic [NREG-1:0] r_en,
  output logic [NREG-1:0] r_out,
  output logic            din_out,
  output logic            g_out,
  output logic            a_en,
  output logic            g_en,
  output logic [1:0]      alu_op,
  output logic            done,
  output logic            busy,
  output logic            err
);

  // Extra encoding beyond T3 is reserved for the optional halt state.
  typedef enum logic [2:0] {
`ifdef PROC_CTRL_HALT_EN
    HALT = 3'd4,
`endif
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
`ifdef PROC_CTRL_HALT_EN
  localparam logic [2:0] OP_HLT = 3'b111;
`endif

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  state_t state;
  state_t nxt;

  logic [DW-1:0]   ir;
  logic [2:0]      opc;
  logic [2:0]      rx;
  logic [2:0]      ry;
  logic [NREG-1:0] rx_sel;
  logic [NREG-1:0] ry_sel;
  logic            is_mv;
  logic            is_mvi;
  logic            is_alu;
  logic            is_halt;
  logic [1:0]      op_sel;
  logic            unused_ir;

  assign opc = ir[DW-1 -: 3];
  assign rx  = ir[DW-4 -: 3];
  assign ry  = ir[DW-7 -: 3];

  assign unused_ir = ^ir[DW-10:0];

  assign rx_sel = NREG'(1) << rx;
  assign ry_sel = NREG'(1) << ry;

  // Classify the latched opcode; anything unclassified is illegal.
  always_comb begin
    is_mv   = 1'b0;
    is_mvi  = 1'b0;
    is_alu  = 1'b0;
    is_halt = 1'b0;
    op_sel  = ALU_ADD;
    unique case (opc)
      OP_MV:  is_mv  = 1'b1;
      OP_MVI: is_mvi = 1'b1;
      OP_ADD: begin
        is_alu = 1'b1;
        op_sel = ALU_ADD;
      end
      OP_SUB: begin
        is_alu = 1'b1;
        op_sel = ALU_SUB;
      end
      OP_AND: begin
        is_alu = 1'b1;
        op_sel = ALU_AND;
      end
`ifdef PROC_CTRL_HALT_EN
      OP_HLT: is_halt = 1'b1;
`endif
      default: ;
    endcase
  end

  // State register; reset forces T0 so all Moore outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= T0;
    end else begin
      state <= nxt;
    end
  end

  // Instruction register: captured only on a run strobe in T0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (state == T0 && run) begin
      ir <= din;
    end
  end

  // Next-state sequencing; run is only looked at in T0.
  always_comb begin
    nxt = state;
    unique case (state)
      T0: begin
        if (run) nxt = T1;
      end
      T1: begin
        nxt = T0;
        if (is_alu) nxt = T2;
`ifdef PROC_CTRL_HALT_EN
        if (is_halt) nxt = HALT;
`endif
      end
      T2: nxt = T3;
      T3: nxt = T0;
`ifdef PROC_CTRL_HALT_EN
      HALT: nxt = HALT;
`endif
      default: nxt = T0;
    endcase
  end

  // Moore output decode from state and latched instruction.
  always_comb begin
    r_en    = '0;
    r_out   = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state != T0);
    unique case (1'b1)
      (state == T0): ;
      (state == T1): begin
        unique case (1'b1)
          is_mv: begin
            r_out = ry_sel;
            r_en  = rx_sel;
            done  = 1'b1;
          end
          is_mvi: begin
            din_out = 1'b1;
            r_en    = rx_sel;
            done    = 1'b1;
          end
          is_alu: begin
            r_out = rx_sel;
            a_en  = 1'b1;
          end
          is_halt: begin
            done = 1'b1;
          end
          default: begin
            err  = 1'b1;
            done = 1'b1;
          end
        endcase
      end
      (state == T2): begin
        r_out  = ry_sel;
        g_en   = 1'b1;
        alu_op = op_sel;
      end
      (state == T3): begin
        g_out = 1'b1;
        r_en  = rx_sel;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_bus_excl: assert property (
    @(posedge clk) disable iff (rst)
    $countones({r_out, din_out, g_out}) <= 1
  );

  a_ren_1hot: assert property (
    @(posedge clk) disable iff (rst)
    $onehot0(r_en)
  );

  a_done_busy: assert property (
    @(posedge clk) disable iff (rst)
    done |-> busy
  );
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: randomized bench for proc_ctrl against an
// instruction-level model that expands each fetch into expected cycles.
module tb_proc_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] din;
  logic [7:0]  r_en;
  logic [7:0]  r_out;
  logic        din_out;
  logic        g_out;
  logic        a_en;
  logic        g_en;
  logic [1:0]  alu_op;
  logic        done;
  logic        busy;
  logic        err;

  int checks;
  int failures;
  int cyc;
  bit halted;
  logic [22:0] q[$];

  proc_ctrl #(.DW(16), .NREG(8)) dut (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .r_en(r_en), .r_out(r_out), .din_out(din_out),
    .g_out(g_out), .a_en(a_en), .g_en(g_en),
    .alu_op(alu_op), .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [22:0] pk(
    input logic [7:0] en, input logic [7:0] ro,
    input logic dio, input logic go,
    input logic ae, input logic ge,
    input logic [1:0] op, input logic dn,
    input logic bz, input logic er);
    return {en, ro, dio, go, ae, ge, op, dn, bz, er};
  endfunction

  function automatic logic [22:0] act();
    return {r_en, r_out, din_out, g_out, a_en, g_en,
            alu_op, done, busy, err};
  endfunction

  // Expand one fetched instruction into its expected output cycles.
  task automatic expand(input logic [15:0] w);
    logic [2:0] o;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] aop;
    o = w[15:13];
    x = 8'd1 << w[12:10];
    y = 8'd1 << w[9:7];
    aop = (o == 3'd3) ? 2'b01 : (o == 3'd4) ? 2'b10 : 2'b00;
    case (o)
      3'd0: q.push_back(pk(x, y, 0, 0, 0, 0, 0, 1, 1, 0));
      3'd1: q.push_back(pk(x, 0, 1, 0, 0, 0, 0, 1, 1, 0));
      3'd2, 3'd3, 3'd4: begin
        q.push_back(pk(0, x, 0, 0, 1, 0, 0, 0, 1, 0));
        q.push_back(pk(0, y, 0, 0, 0, 1, aop, 0, 1, 0));
        q.push_back(pk(x, 0, 0, 1, 0, 0, 0, 1, 1, 0));
      end
`ifdef PROC_CTRL_HALT_EN
      3'd7: begin
        q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        halted = 1'b1;
      end
`endif
      default: q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    endcase
  endtask

  // One clock: check this cycle's outputs, then drive next inputs.
  task automatic step(input logic rv, input logic [15:0] dv);
    logic [22:0] exp;
    bit idle;
    @(posedge clk);
    #1;
    cyc++;
    idle = (q.size() == 0) && !halted;
    if (q.size() != 0) exp = q.pop_front();
    else if (halted) exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    else exp = '0;
    check("outs", 32'(act()), 32'(exp));
    check("bus_excl",
          32'($countones({r_out, din_out, g_out}) <= 1), 32'd1);
    run = rv;
    din = dv;
    if (idle && rv) expand(dv);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", 32'(act()), 32'd0);
    q.delete();
    halted = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int dc[$];
    logic [15:0] w;
    checks = 0;
    failures = 0;
    cyc = 0;
    halted = 1'b0;
    rst = 1'b1;
    run = 1'b0;
    din = '0;
    #3;
    check("reset", 32'(act()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 16'h0);

    step(1, 16'h0400);
    step(0, 16'h0);
    step(0, 16'h0);

    step(1, 16'h2C00);
    step(0, 16'h1234);
    step(0, 16'h0);

    step(1, 16'h6500);
    step(0, 16'h0);
    step(0, 16'h0);
    step(0, 16'h0);
    step(0, 16'h0);

    step(1, 16'hA000);
    step(0, 16'h0);
    step(0, 16'h0);

    step(1, 16'h4A80);
    step(1, 16'hFFFF);
    step(1, 16'hFFFF);
    do_reset();
    step(0, 16'h0);
    step(1, 16'h0480);
    step(0, 16'h0);
    step(0, 16'h0);

    step(1, 16'h1D00);
    step(0, 16'h0);
    step(0, 16'h0);

    for (int i = 0; i < 12; i++) begin
      step(1, 16'h8A00);
      if (done) dc.push_back(cyc);
    end
    run = 1'b0;
    check("b2b_cnt", 32'(dc.size()), 32'd3);
    if (dc.size() == 3) begin
      check("b2b_gap0", 32'(dc[1] - dc[0]), 32'd4);
      check("b2b_gap1", 32'(dc[2] - dc[1]), 32'd4);
    end
    step(0, 16'h0);
    step(0, 16'h0);

    for (int i = 0; i < 2500; i++) begin
      w = 16'($urandom);
`ifdef PROC_CTRL_HALT_EN
      if (w[15:13] == 3'd7) w[15:13] = 3'd5;
`endif
      step(logic'($urandom_range(0, 2) != 0), w);
      if ($urandom_range(0, 300) == 0) do_reset();
    end
    step(0, 16'h0);
    step(0, 16'h0);
    step(0, 16'h0);
    step(0, 16'h0);

    step(1, 16'hE000);
    step(0, 16'h0);
`ifdef PROC_CTRL_HALT_EN
    for (int i = 0; i < 20; i++) step(logic'(i % 2 == 0), 16'h0400);
    do_reset();
`endif
    step(0, 16'h0);
    step(1, 16'h0400);
    step(0, 16'h0);
    step(0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
Multi-cycle control FSM for the 16-bit register-based datapath. It fetches an instruction word from din and drives the write enables of the general-purpose registers (R0-R7, accumulator A, result G). It also drives the one-hot tri-state bus drive selects and the ALU opcode. Only one source is guaranteed to drive the shared bus in any cycle.

Parameters:
DW, 16, instruction/data word width (din width).
NREG, 8, number of general registers; width of r_en/r_out; register fields are 3 bits, so NREG must be 8.

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  asynchronous active-high reset.
run  input  1  start strobe; sampled only in T0.
din  input  DW  instruction word (in T0) / immediate operand (in T1 of mvi).
r_en  output  NREG  one-hot write enable for R0..R7.
r_out  output  NREG  one-hot bus drive select for R0..R7.
din_out  output  1  drive din onto bus.
g_out  output  1  drive G onto bus.
a_en  output  1  write enable for A.
g_en  output  1  write enable for G.
alu_op  output  2  00 add, 01 sub, 10 and, 11 unused (drive 00).
done  output  1  one-cycle pulse on the final cycle of an instruction.
busy  output  1  high whenever state != T0.
err  output  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Instruction fields: opcode = din[15:13], rx = din[12:10], ry = din[9:7]; din[6:0] ignored.
- Opcodes: 000 mv (rx<-ry), 001 mvi (rx<-next din), 010 add, 011 sub, 100 and (rx<-rx op ry), 101-111 illegal.
- Internal IR, DW bits, loaded from din on posedge when state=T0 and run=1. It is not loaded at any other time.
- States: T0 (idle/fetch), T1, T2, T3. State register and IR both reset asynchronously to T0 / 0.
- Outputs are decoded combinationally from state and IR (Moore). All outputs are 0 in T0, except busy=0.
- T0: when run=1, go to T1; otherwise stay in T0.
- T1, mv: r_out[ry]=1, r_en[rx]=1, done=1; next state T0.
- T1, mvi: din_out=1, r_en[rx]=1, done=1; next state T0. The external source holds the immediate on din during this cycle.
- T1, add/sub/and: r_out[rx]=1, a_en=1; next state T2.
- T1, illegal: err=1, done=1, no enables asserted; next state T0.
- T2: r_out[ry]=1, g_en=1, alu_op per opcode; next state T3.
- T3: g_out=1, r_en[rx]=1, done=1; next state T0.
- Latencies: mv/mvi/illegal take 2 cycles from the run sample to the done cycle inclusive; ALU ops take 4.
- Invariants checked every cycle:
  - At most one of {any r_out bit, din_out, g_out} is high.
  - r_en is one-hot or zero.
  - done and busy are high together only in the final cycle.
- run in T1-T3 is ignored; no queuing. Back-to-back operation: run held high re-fetches in the T0 cycle after done.
- rx == ry is legal. mv Rx,Rx asserts r_out[x] and r_en[x] in the same cycle, and the register reloads its own value.
- Reset mid-instruction: all outputs drop to 0 immediately (asynchronously), with no partial done. Operation resumes in T0 after rst deasserts.

Optional Feature:
PROC_CTRL_HALT_EN
- Defined: opcode 111 is halt. In T1 it asserts done=1 and enters state HALT. In HALT, busy=1, all enables are 0, and run is ignored; only rst exits.
- Undefined: 111 is illegal (err pulse, return to T0), and the HALT state does not exist.

Test Plan:
- rst mid-T2 of an add -> all outputs 0 in the same cycle; T0 after release; next run fetches normally.
- run with din=0x0400 (mv R1,R0) -> T1: r_out=0x01, r_en=0x02, done=1; busy high for 1 cycle.
- run with din=0x2C00 (mvi R3), then din=0x1234 -> T1: din_out=1, r_en=0x08, done=1; bus value 0x1234.
- run with din=0x6500 (sub R1,R2) -> T1 r_out=0x02,a_en; T2 r_out=0x04,g_en,alu_op=01; T3 g_out,r_en=0x02,done.
- run with din=0xA000 (opcode 101) -> T1 err=1, done=1, r_en=0; T0 next cycle. Opcode 111 with PROC_CTRL_HALT_EN defined -> HALT, busy stuck at 1 across 10 run pulses.
- run held high across 3 consecutive ALU ops -> done pulses 4 cycles apart; the bus-exclusivity assertion never fires.
